// File: rtl/sevenseg_scan_n.sv
// Time-multiplexed N-digit common-anode seven-segment driver with dead-time blanking and frame-synchronous double buffering.
// Optional leading-zero suppression: define SEVENSEG_LEADING_ZERO_BLANK_EN.
module sevenseg_scan_n #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned ON_CYCLES    = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         digit_mask,
    input  logic                          load,
    output logic [NUM_DIGITS-1:0]         enseg,
    output logic [6:0]                    sevenseg,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
    output logic                          frame_done
);

    localparam int unsigned IW      = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("sevenseg_scan_n: NUM_DIGITS must be in 2..8");
    end
    if (ON_CYCLES < 1) begin : g_bad_on_cycles
        $error("sevenseg_scan_n: ON_CYCLES must be at least 1");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank_cycles
        $error("sevenseg_scan_n: BLANK_CYCLES must be at least 1");
    end

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] active;

    logic [3:0]              cur_nib;
    logic                    cur_mask;
    logic                    show;
    logic [NUM_DIGITS-1:0]   en_next;
    logic                    scan_last;
    logic                    blank_end;
    logic                    on_end;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    logic [IW-1:0]           lz_hi;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0011000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Select the nibble and mask bit of the digit about to be driven.
    always_comb begin
        cur_nib  = 4'd0;
        cur_mask = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (IW'(i) == scan_idx) begin
                cur_nib  = active[4*i +: 4];
                cur_mask = digit_mask[i];
            end
        end
    end

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    // Highest non-zero digit of the active buffer; 0 when all digits are zero.
    always_comb begin
        lz_hi = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (active[4*i +: 4] != 4'd0) begin
                lz_hi = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        show = cur_mask;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
        if (scan_idx > lz_hi) begin
            show = 1'b0;
        end
`endif
        en_next = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (show && (IW'(i) == scan_idx)) begin
                en_next[i] = 1'b0;
            end
        end
    end

    assign scan_last = (scan_idx == IW'(NUM_DIGITS - 1));
    assign blank_end = (cnt == CW'(BLANK_CYCLES - 1));
    assign on_end    = (cnt == CW'(ON_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            scan_idx   <= '0;
            pending    <= '0;
            active     <= '0;
            enseg      <= '1;
            sevenseg   <= 7'b1111111;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load) begin
                pending <= digits_in;
            end
            case (state)
                ST_BLANK: begin
                    if (blank_end) begin
                        state    <= ST_ON;
                        cnt      <= '0;
                        enseg    <= en_next;
                        sevenseg <= show ? glyph(cur_nib) : 7'b1111111;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_ON: begin
                    if (on_end) begin
                        state    <= ST_BLANK;
                        cnt      <= '0;
                        enseg    <= '1;
                        sevenseg <= 7'b1111111;
                        if (scan_last) begin
                            // Frame boundary: a coincident load bypasses pending so the newest data wins.
                            scan_idx   <= '0;
                            frame_done <= 1'b1;
                            active     <= load ? digits_in : pending;
                        end else begin
                            scan_idx <= scan_idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/sevenseg_scan_n.md
Name: sevenseg_scan_n

Overview:
- Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display.
- Scans NUM_DIGITS hex nibbles onto one shared active-low segment bus with per-digit active-low enables.
- Inserts a programmable dead-time blank between digits to suppress ghosting.
- Double-buffers displayed data so updates take effect only at frame boundaries, giving tear-free displays.
- Sits between switch/keypad/counter logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 2 to 8.
- ON_CYCLES, 50000, clocks each digit is driven per scan slot; must be at least 1.
- BLANK_CYCLES, 500, dead-time clocks with all digits off before each ON slot; must be at least 1.

Ports:
- clk  input  1  system clock (24 MHz on board).
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- digits_in  input  4*NUM_DIGITS  hex nibbles; nibble i is bits [4i+3:4i]; digit 0 is least significant.
- digit_mask  input  NUM_DIGITS  1 = digit i shown, 0 = digit i kept dark; sampled live each slot.
- load  input  1  single-cycle strobe; captures digits_in into the pending buffer.
- enseg  output  NUM_DIGITS  active-low digit enables.
- sevenseg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- scan_idx  output  $clog2(NUM_DIGITS)  index of the current or next digit slot.
- frame_done  output  1  one-cycle pulse at the end of each full scan.

Behaviour:
- All outputs are registered. Internal state: a two-state FSM (BLANK, ON), a slot counter sized for max(ON_CYCLES, BLANK_CYCLES), scan_idx, a pending buffer and an active buffer.
- Reset (reset=0 at a rising edge):
  - state=BLANK, counter=0, scan_idx=0.
  - pending=0, active=0.
  - enseg all 1, sevenseg=7'b1111111, frame_done=0.
  - Reset asserted mid-slot aborts the scan immediately on that edge.
- BLANK state:
  - enseg all 1, sevenseg=7'b1111111.
  - Lasts exactly BLANK_CYCLES clocks, then goes to ON.
  - On entry to ON: enseg[scan_idx]=0 if digit_mask[scan_idx]=1; sevenseg=glyph(active[scan_idx]).
- ON state:
  - Lasts exactly ON_CYCLES clocks, then goes to BLANK.
  - On the exit edge, scan_idx increments. At scan_idx=NUM_DIGITS-1 it wraps to 0 and the frame-boundary actions below fire on that same edge.
  - A masked digit still occupies its full slot with enseg high and sevenseg all-off, so the refresh rate and the brightness of other digits are unchanged.
  - digit_mask changes take effect at the next ON entry.
- Timing:
  - Slot period = BLANK_CYCLES+ON_CYCLES.
  - Frame period = NUM_DIGITS*(BLANK_CYCLES+ON_CYCLES).
  - After reset releases, the first digit-0 enable asserts BLANK_CYCLES clocks later.
  - Digits are enabled one-hot; at most one enseg bit is low at any time.
- Frame-boundary actions (exit edge of ON with scan_idx=NUM_DIGITS-1):
  - frame_done=1 for exactly that following cycle.
  - active<=pending.
- Buffering and load:
  - load=1 sets pending<=digits_in on that edge.
  - If load coincides with a frame boundary, active<=digits_in directly on that edge (the newest data wins) and pending<=digits_in.
  - Multiple loads within one frame: only the last one is displayed.
- Glyph table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Parameter violations (ON_CYCLES<1, BLANK_CYCLES<1, NUM_DIGITS outside 2..8) are reported with an elaboration-time $error.

Optional Feature:
- Macro: SEVENSEG_LEADING_ZERO_BLANK_EN.
- When defined:
  - Any active digit i above the highest non-zero active digit is treated as masked (enseg high, sevenseg all-off).
  - Digit 0 is always shown, subject to digit_mask.
  - Suppression is evaluated from the active buffer at ON entry.
- When undefined: all digits are displayed per digit_mask only, and zeros are shown as "0".

Test Plan:
- Simulation parameters for all scenarios: NUM_DIGITS=4, ON_CYCLES=4, BLANK_CYCLES=2.
- Reset, then load digits_in=16'h1A2F, mask=4'hF -> first frame shows all 0 glyphs. From frame 2, the enseg low sequence is 1110, 1101, 1011, 0111 with sevenseg F, 2, A, 1. Each enable is low for 4 clocks, separated by 2 all-high clocks; frame_done pulses every 24 clocks.
- Hold reset low 30 clocks, release -> enseg=1111 and sevenseg=1111111 throughout reset; enseg[0] falls exactly 2 clocks after release.
- digit_mask=4'b1011 with data 16'h8888 -> enseg[2] never low, and the slot-2 timing gap is still 6 clocks; the other digits show 0000000.
- Pulse load with 16'h0001 mid-frame, then with 16'h0002 in the same frame -> no glyph changes until the frame boundary; the next frame shows 2 on digit 0. Load asserted on the frame-boundary cycle -> that data is displayed in the very next frame.
- Reset asserted during an ON slot of digit 2 -> on the next edge enseg=1111, scan_idx=0, and the active buffer is cleared.
- With SEVENSEG_LEADING_ZERO_BLANK_EN and data 16'h0030 -> digits 3 and 2 dark, digit 1 shows 3, digit 0 shows 0. With 16'h0000, only digit 0 is lit, showing 0.
